spi_bus_sequencer: RTL and testbench
====================================

# spi_bus_sequencer

Converts a byte stream from the SPI peripheral into timed Xosera register bus cycles, so an SPI-only host can drive the full `xosera_main` bus. The block sits between `spi_target` and `xosera_main` in the iCEBreaker top level, under the `SPI_INTERFACE` build. It owns CS pulse width, read-data capture and soft reset, and keeps a host-visible overrun flag.

## Interface
- `BUS_HOLD`, default 2: cycles `bus_cs_n_o` is held low per bus cycle. Legal range 1–15.
- `IDLE_BYTE`, default 8'hCB: byte returned to the host when no read data is pending.
- `clk` in 1: pixel clock (`pclk`). The block uses one clock only.
- `reset_i` in 1: synchronous, active-high reset.
- `spi_select_i` in 1: SPI chip select, active-high, from `spi_target`.
- `spi_rx_strobe_i` in 1: one-cycle pulse when a received byte is valid.
- `spi_rx_byte_i` in 8: received byte.
- `spi_tx_byte_o` out 8: byte `spi_target` shifts out next.
- `bus_cs_n_o` out 1: bus select, active-low.
- `bus_rd_nwr_o` out 1: 1 = read, 0 = write.
- `bus_bytesel_o` out 1: 0 = even byte, 1 = odd byte.
- `bus_reg_num_o` out 4: register index.
- `bus_data_o` out 8: write data to `xosera_main`.
- `bus_data_i` in 8: read data from `xosera_main`.
- `soft_reset_o` out 1: one-cycle reset request.
- `overrun_o` out 1: sticky flag, set when a byte is dropped.

## Operation
- Command byte format: [7] CS, [6] WR, [5] RS, [4] BS, [3:0] REG. All bits are active-high.
- States:
  - CMD: waiting for a command byte.
  - DATA: waiting for a payload byte.
  - BUS: a bus cycle is in progress, with a hold counter.
  - RET: the cycle has finished; decide the next state.
- CMD, byte received:
  - RS=1: pulse `soft_reset_o` and stay in CMD. The command has no payload.
  - Otherwise: latch REG, BS and WR.
  - Read (WR=0, CS=1): go to BUS to launch the read immediately.
  - Write, or CS=0: go to DATA.
- DATA, byte received:
  - Latch the byte into `bus_data_o`.
  - CS=1: go to BUS.
  - CS=0: no-op packet; go to RET.
- BUS:
  - Drive `bus_cs_n_o`=0 for exactly `BUS_HOLD` cycles.
  - `bus_rd_nwr_o`, `bus_bytesel_o`, `bus_reg_num_o` and `bus_data_o` are stable for the whole assertion and one cycle before it.
  - On the last CS-low cycle of a read, `bus_data_i` is registered into `spi_tx_byte_o`.
- RET:
  - After a write packet or a no-op packet, go to CMD.
  - After a read command, go to DATA. The payload byte clocks the read data out.
  - On that payload byte, go to CMD, or continue a burst (see Configuration).
- `spi_tx_byte_o` reloads `IDLE_BYTE` on every entry to CMD.
- Overrun: a byte strobe while in BUS or RET is dropped and `overrun_o` is set. `overrun_o` clears only on `reset_i` or on an RS command.
- `spi_select_i` deasserted:
  - In CMD, DATA or RET: return to CMD on the next cycle.
  - In BUS: finish the current CS pulse in full (never truncate it), then go to CMD.

## Timing
- Reset values: `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_bytesel_o`=0, `bus_reg_num_o`=0, `bus_data_o`=0, `spi_tx_byte_o`=`IDLE_BYTE`, `soft_reset_o`=0, `overrun_o`=0. State resets to CMD.
- `reset_i` mid-cycle: `bus_cs_n_o` goes high on the next edge. Whatever was in progress is abandoned.
- Strobe to CS low: 2 cycles. Strobe at edge N, control outputs update at N+1, CS falls at N+2.
- CS low spans cycles N+2 through N+1+`BUS_HOLD`.
- Minimum gap between strobes: 2+`BUS_HOLD`+1 cycles. Any SPI clock ≤ pclk/4 satisfies this.
- `soft_reset_o` rises the cycle after the RS strobe and lasts exactly 1 cycle.

## Configuration
- `SPI_BURST_EN` defined:
  - After the bus cycle of a CS=1 packet, stay in DATA until `spi_select_i` drops.
  - Each further payload byte toggles `bus_bytesel_o` and runs another cycle on the same REG, alternating even/odd.
  - In a read burst, each payload byte returns the previous read and launches the next one.
- `SPI_BURST_EN` undefined: exactly one bus cycle per packet, and the block returns to CMD after each packet.

## Test plan
- Write: cmd 8'hC3, payload 8'h5A → one CS-low pulse of 2 cycles with reg=3, rd_nwr=0, bytesel=0, data=8'h5A. Then back in CMD with `spi_tx_byte_o`=8'hCB.
- Read: cmd 8'h92, `bus_data_i`=8'hA7 → one CS pulse with reg=2, rd_nwr=1, bytesel=1. `spi_tx_byte_o`=8'hA7 before the payload strobe; after that byte, back in CMD with 8'hCB.
- Soft reset: cmd 8'h20 → `soft_reset_o` high for exactly 1 cycle, no CS pulse, `overrun_o` cleared.
- Overrun and select drop: a second strobe one cycle after a write payload → `overrun_o`=1 and exactly one CS pulse. Drop `spi_select_i` during BUS → the CS pulse still lasts the full 2 cycles.
- `reset_i` asserted on the first CS-low cycle → `bus_cs_n_o`=1 the next cycle and every output at its reset value.
- With `SPI_BURST_EN`: cmd 8'hC5, payloads 11, 22, 33 → three CS pulses with bytesel 0,1,0 on reg 5. Without it, the second byte (22) is decoded as a command.

Source files
------------

// File: rtl/spi_bus_sequencer.sv
// spi_bus_sequencer
//   Turns the byte stream from spi_target into timed xosera_main register
//   bus cycles. Owns the bus CS pulse width, read-data capture, soft reset
//   requests and a sticky overrun flag.
//
//   Command byte: [7] CS, [6] WR, [5] RS, [4] BS, [3:0] REG.
//
//   Parameters:
//     BUS_HOLD  - cycles bus_cs_n_o stays low per bus cycle (1..15)
//     IDLE_BYTE - byte returned to the host when no read data is pending
//
//   Ports:
//     clk, reset_i         - pixel clock, synchronous active-high reset
//     spi_select_i         - SPI chip select (active-high)
//     spi_rx_strobe_i/byte - received byte and its one-cycle valid pulse
//     spi_tx_byte_o        - next byte shifted out to the host
//     bus_*_o / bus_data_i - xosera_main register bus
//     soft_reset_o         - one-cycle soft reset request
//     overrun_o            - sticky flag: a byte arrived while busy
//
//   Build option: SPI_BURST_EN - after the bus cycle of a CS=1 packet stay
//   in DATA; each further payload byte runs another cycle on the same
//   register with the byte select toggled.
module spi_bus_sequencer #(
    parameter int unsigned BUS_HOLD  = 2,
    parameter logic [7:0]  IDLE_BYTE = 8'hCB
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       spi_select_i,
    input  logic       spi_rx_strobe_i,
    input  logic [7:0] spi_rx_byte_i,
    output logic [7:0] spi_tx_byte_o,
    output logic       bus_cs_n_o,
    output logic       bus_rd_nwr_o,
    output logic       bus_bytesel_o,
    output logic [3:0] bus_reg_num_o,
    output logic [7:0] bus_data_o,
    input  logic [7:0] bus_data_i,
    output logic       soft_reset_o,
    output logic       overrun_o
);

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [3:0] HOLD_LAST = 4'(BUS_HOLD);

    typedef enum logic [1:0] {
        ST_CMD,
        ST_DATA,
        ST_BUS,
        ST_RET
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [3:0] r_hold;     // 0 = setup cycle, 1..BUS_HOLD = CS-low cycles
    logic       r_cs;       // CS bit of the current packet
    logic       r_read;     // a read command has been launched
    logic       r_burst;    // further payload bytes run more bus cycles
    logic       r_drop;     // select fell during the current bus cycle

    logic       r_cs_n;
    logic       r_rd_nwr;
    logic       r_bytesel;
    logic [3:0] r_reg;
    logic [7:0] r_data;
    logic [7:0] r_tx;
    logic       r_soft;
    logic       r_ovr;

    logic       w_cmd_cs;
    logic       w_cmd_wr;
    logic       w_cmd_rs;
    logic       w_cmd_bs;
    logic       w_latch_cmd;
    logic       w_latch_data;
    logic       w_toggle;
    logic       w_soft;
    logic       w_drop_byte;
    logic       w_hold_done;

    assign w_cmd_cs    = spi_rx_byte_i[7];
    assign w_cmd_wr    = spi_rx_byte_i[6];
    assign w_cmd_rs    = spi_rx_byte_i[5];
    assign w_cmd_bs    = spi_rx_byte_i[4];
    assign w_hold_done = (r_hold == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch_cmd  = 1'b0;
        w_latch_data = 1'b0;
        w_toggle     = 1'b0;
        w_soft       = 1'b0;
        w_drop_byte  = 1'b0;
        case (r_state)
            ST_CMD: begin
                if (spi_select_i && spi_rx_strobe_i) begin
                    if (w_cmd_rs) begin
                        w_soft = 1'b1;
                    end else begin
                        w_latch_cmd = 1'b1;
                        w_next      = (w_cmd_cs && !w_cmd_wr) ? ST_BUS : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!spi_select_i) begin
                    w_next = ST_CMD;
                end else if (spi_rx_strobe_i) begin
                    w_latch_data = 1'b1;
                    if (r_burst) begin
                        w_toggle = 1'b1;
                        w_next   = ST_BUS;
                    end else if (r_read) begin
                        w_next = ST_CMD;
                    end else if (r_cs) begin
                        w_next = ST_BUS;
                    end else begin
                        w_next = ST_RET;
                    end
                end
            end
            ST_BUS: begin
                w_drop_byte = spi_rx_strobe_i;
                // The CS pulse always runs to completion; a select drop
                // seen at any point during it only redirects the exit.
                if (w_hold_done) begin
                    w_next = (r_drop || !spi_select_i) ? ST_CMD : ST_RET;
                end
            end
            ST_RET: begin
                w_drop_byte = spi_rx_strobe_i;
                if (!spi_select_i) begin
                    w_next = ST_CMD;
                end else if (r_read || (BURST && r_cs)) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_CMD;
                end
            end
            default: w_next = ST_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_hold    <= '0;
            r_cs      <= 1'b0;
            r_read    <= 1'b0;
            r_burst   <= 1'b0;
            r_drop    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_nwr  <= 1'b1;
            r_bytesel <= 1'b0;
            r_reg     <= '0;
            r_data    <= '0;
            r_tx      <= IDLE_BYTE;
            r_soft    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_soft <= w_soft;
            if (w_soft) begin
                r_ovr <= 1'b0;
            end else if (w_drop_byte) begin
                r_ovr <= 1'b1;
            end

            if (w_latch_cmd) begin
                r_reg     <= spi_rx_byte_i[3:0];
                r_bytesel <= w_cmd_bs;
                r_rd_nwr  <= ~w_cmd_wr;
                r_cs      <= w_cmd_cs;
                r_read    <= w_cmd_cs & ~w_cmd_wr;
            end
            if (w_latch_data) begin
                r_data <= spi_rx_byte_i;
            end
            if (w_toggle) begin
                r_bytesel <= ~r_bytesel;
            end

            // Controls were latched on entry, so the setup cycle gives them
            // one full cycle of stability before CS falls.
            if (r_state == ST_BUS) begin
                if (!spi_select_i) begin
                    r_drop <= 1'b1;
                end
                if (r_hold == '0) begin
                    r_cs_n <= 1'b0;
                    r_hold <= 4'd1;
                end else if (w_hold_done) begin
                    r_cs_n <= 1'b1;
                    r_hold <= '0;
                    r_drop <= 1'b0;
                    if (r_rd_nwr) begin
                        r_tx <= bus_data_i;
                    end
                end else begin
                    r_hold <= r_hold + 4'd1;
                end
            end

            if (r_state == ST_RET && w_next == ST_DATA) begin
                r_burst <= BURST && r_cs;
            end

            // Placed last so the idle byte wins over a read capture that
            // coincides with an exit straight to CMD.
            if (w_next == ST_CMD && r_state != ST_CMD) begin
                r_tx    <= IDLE_BYTE;
                r_burst <= 1'b0;
                r_read  <= 1'b0;
            end
        end
    end

    assign spi_tx_byte_o = r_tx;
    assign bus_cs_n_o    = r_cs_n;
    assign bus_rd_nwr_o  = r_rd_nwr;
    assign bus_bytesel_o = r_bytesel;
    assign bus_reg_num_o = r_reg;
    assign bus_data_o    = r_data;
    assign soft_reset_o  = r_soft;
    assign overrun_o     = r_ovr;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
module tb_spi_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       spi_select_i = 1'b0;
    logic       spi_rx_strobe_i = 1'b0;
    logic [7:0] spi_rx_byte_i = 8'h00;
    logic [7:0] spi_tx_byte_o;
    logic       bus_cs_n_o;
    logic       bus_rd_nwr_o;
    logic       bus_bytesel_o;
    logic [3:0] bus_reg_num_o;
    logic [7:0] bus_data_o;
    logic [7:0] bus_data_i = 8'h00;
    logic       soft_reset_o;
    logic       overrun_o;

    spi_bus_sequencer #(.BUS_HOLD(2), .IDLE_BYTE(8'hCB)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .spi_select_i    (spi_select_i),
        .spi_rx_strobe_i (spi_rx_strobe_i),
        .spi_rx_byte_i   (spi_rx_byte_i),
        .spi_tx_byte_o   (spi_tx_byte_o),
        .bus_cs_n_o      (bus_cs_n_o),
        .bus_rd_nwr_o    (bus_rd_nwr_o),
        .bus_bytesel_o   (bus_bytesel_o),
        .bus_reg_num_o   (bus_reg_num_o),
        .bus_data_o      (bus_data_o),
        .bus_data_i      (bus_data_i),
        .soft_reset_o    (soft_reset_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus monitor, sampled on the falling edge.
    int         pulses   = 0;
    int         cur_w    = 0;
    int         last_w   = 0;
    int         stab_err = 0;
    int         soft_cnt = 0;
    int         cur_sw   = 0;
    int         last_sw  = 0;
    logic [3:0] cap_reg  = '0;
    logic       cap_rd   = 1'b0;
    logic       cap_bs   = 1'b0;
    logic [7:0] cap_data = '0;
    logic [3:0] p_reg    = '0;
    logic       p_rd     = 1'b0;
    logic       p_bs     = 1'b0;
    logic [7:0] p_data   = '0;

    always @(negedge clk) begin
        if (!bus_cs_n_o) begin
            cur_w    = cur_w + 1;
            cap_reg  = bus_reg_num_o;
            cap_rd   = bus_rd_nwr_o;
            cap_bs   = bus_bytesel_o;
            cap_data = bus_data_o;
            if (bus_reg_num_o != p_reg || bus_rd_nwr_o != p_rd ||
                bus_bytesel_o != p_bs || bus_data_o != p_data)
                stab_err = stab_err + 1;
        end else if (cur_w != 0) begin
            pulses = pulses + 1;
            last_w = cur_w;
            cur_w  = 0;
        end
        p_reg  = bus_reg_num_o;
        p_rd   = bus_rd_nwr_o;
        p_bs   = bus_bytesel_o;
        p_data = bus_data_o;
        if (soft_reset_o) begin
            cur_sw = cur_sw + 1;
        end else if (cur_sw != 0) begin
            soft_cnt = soft_cnt + 1;
            last_sw  = cur_sw;
            cur_sw   = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        spi_rx_byte_i   = b;
        spi_rx_strobe_i = 1'b1;
        tick();
        spi_rx_strobe_i = 1'b0;
    endtask

    task automatic deselect();
        spi_select_i = 1'b0;
        idle(2);
        spi_select_i = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] pay;
        logic [7:0] din;
        bit         rd;
        int         npulse;
        logic [3:0] rnum;
        logic       rd_nwr;
        logic       bs;
        logic [7:0] data;
    } vec_t;

    vec_t vt[5];

    initial begin
        int p0;
        int s0;
        int sw0;
        int k;

        // cmd,  payload, bus_data_i, read, pulses, reg, rd_nwr, bytesel, data
        vt[0] = '{8'hC3, 8'h5A, 8'h00, 1'b0, 1, 4'h3, 1'b0, 1'b0, 8'h5A};
        vt[1] = '{8'h92, 8'h00, 8'hA7, 1'b1, 1, 4'h2, 1'b1, 1'b1, 8'h00};
        vt[2] = '{8'hD7, 8'h3C, 8'h00, 1'b0, 1, 4'h7, 1'b0, 1'b1, 8'h3C};
        vt[3] = '{8'h40, 8'h99, 8'h00, 1'b0, 0, 4'h0, 1'b0, 1'b0, 8'h99};
        vt[4] = '{8'h8F, 8'h00, 8'h5E, 1'b1, 1, 4'hF, 1'b1, 1'b0, 8'h00};

        idle(3);
        check("rst_cs_n",  bus_cs_n_o,    1);
        check("rst_rdnwr", bus_rd_nwr_o,  1);
        check("rst_bs",    bus_bytesel_o, 0);
        check("rst_reg",   bus_reg_num_o, 0);
        check("rst_data",  bus_data_o,    0);
        check("rst_tx",    spi_tx_byte_o, 8'hCB);
        check("rst_soft",  soft_reset_o,  0);
        check("rst_ovr",   overrun_o,     0);
        reset_i      = 1'b0;
        spi_select_i = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            bus_data_i = vt[i].din;
            p0 = pulses;
            s0 = stab_err;
            send(vt[i].cmd);
            idle(8);
            if (vt[i].rd) begin
                check($sformatf("v%0d_pulses", i), pulses - p0, vt[i].npulse);
                check($sformatf("v%0d_tx_rd", i), spi_tx_byte_o, vt[i].din);
                send(vt[i].pay);
                idle(8);
`ifndef SPI_BURST_EN
                check($sformatf("v%0d_tx_after", i), spi_tx_byte_o, 8'hCB);
`endif
            end else begin
                send(vt[i].pay);
                idle(8);
                check($sformatf("v%0d_pulses", i), pulses - p0, vt[i].npulse);
                check($sformatf("v%0d_data_o", i), bus_data_o, vt[i].data);
            end
            if (vt[i].npulse != 0) begin
                check($sformatf("v%0d_width", i), last_w, 2);
                check($sformatf("v%0d_reg", i), cap_reg, vt[i].rnum);
                check($sformatf("v%0d_rdnwr", i), cap_rd, vt[i].rd_nwr);
                check($sformatf("v%0d_bs", i), cap_bs, vt[i].bs);
                if (!vt[i].rd) check($sformatf("v%0d_cap_data", i), cap_data, vt[i].data);
            end
            check($sformatf("v%0d_stable", i), stab_err - s0, 0);
            deselect();
            check($sformatf("v%0d_tx_idle", i), spi_tx_byte_o, 8'hCB);
        end

        // Overrun plus select drop during the bus cycle.
        p0 = pulses;
        send(8'hC3);
        idle(8);
        send(8'h5A);
        send(8'h00);
        spi_select_i = 1'b0;
        idle(8);
        check("ovr_pulses", pulses - p0, 1);
        check("ovr_width",  last_w, 2);
        check("ovr_flag",   overrun_o, 1);
        check("ovr_tx",     spi_tx_byte_o, 8'hCB);
        spi_select_i = 1'b1;
        idle(2);
        check("ovr_sticky", overrun_o, 1);

        // Soft reset clears overrun, no bus cycle.
        p0  = pulses;
        sw0 = soft_cnt;
        send(8'h20);
        check("srst_high", soft_reset_o, 1);
        tick();
        check("srst_low",  soft_reset_o, 0);
        idle(6);
        check("srst_cnt",    soft_cnt - sw0, 1);
        check("srst_width",  last_sw, 1);
        check("srst_ovr",    overrun_o, 0);
        check("srst_nopulse", pulses - p0, 0);

        // Reset during the first CS-low cycle.
        send(8'hC3);
        idle(8);
        send(8'h77);
        send(8'h00);
        k = 0;
        while (bus_cs_n_o && k < 20) begin
            tick();
            k++;
        end
        check("mid_cs_low",  bus_cs_n_o, 0);
        check("mid_ovr_pre", overrun_o, 1);
        reset_i = 1'b1;
        tick();
        check("mid_cs_n",  bus_cs_n_o,    1);
        check("mid_rdnwr", bus_rd_nwr_o,  1);
        check("mid_bs",    bus_bytesel_o, 0);
        check("mid_reg",   bus_reg_num_o, 0);
        check("mid_data",  bus_data_o,    0);
        check("mid_tx",    spi_tx_byte_o, 8'hCB);
        check("mid_soft",  soft_reset_o,  0);
        check("mid_ovr",   overrun_o,     0);
        reset_i = 1'b0;
        idle(3);

        // Burst on register 5 (or command re-decode without bursts).
        p0  = pulses;
        sw0 = soft_cnt;
        send(8'hC5);
        idle(8);
        send(8'h11);
        idle(8);
        check("bst1_pulses", pulses - p0, 1);
        check("bst1_bs",     cap_bs, 0);
        check("bst1_reg",    cap_reg, 5);
        send(8'h22);
        idle(8);
`ifdef SPI_BURST_EN
        check("bst2_pulses", pulses - p0, 2);
        check("bst2_bs",     cap_bs, 1);
        check("bst2_data",   cap_data, 8'h22);
        send(8'h33);
        idle(8);
        check("bst3_pulses", pulses - p0, 3);
        check("bst3_bs",     cap_bs, 0);
        check("bst3_reg",    cap_reg, 5);
        check("bst3_data",   cap_data, 8'h33);
`else
        check("nb2_pulses", pulses - p0, 1);
        check("nb2_soft",   soft_cnt - sw0, 1);
        send(8'h33);
        idle(8);
        check("nb3_pulses", pulses - p0, 1);
        check("nb3_soft",   soft_cnt - sw0, 2);
`endif
        deselect();
        check("bst_tx_idle", spi_tx_byte_o, 8'hCB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
